// File: rtl/alu_arbiter_pkg.sv
// Shared ALU control codes and arbiter state encoding for alu_arbiter and its ALU.
package alu_arbiter_pkg;

  localparam logic [2:0] CTRL_AND = 3'b000;
  localparam logic [2:0] CTRL_OR  = 3'b001;
  localparam logic [2:0] CTRL_ADD = 3'b010;
  localparam logic [2:0] CTRL_SUB = 3'b100;
  localparam logic [2:0] CTRL_MUL = 3'b101;
  localparam logic [2:0] CTRL_SLT = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MULW = 2'd2
  } state_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU shared by both arbiter ports; unknown control codes give 0.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 3
) (
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  input  logic [CTRL_WIDTH-1:0] ctrl,
  output logic [DATA_WIDTH-1:0] result
);

  localparam logic [CTRL_WIDTH-1:0] C_AND = CTRL_WIDTH'(CTRL_AND);
  localparam logic [CTRL_WIDTH-1:0] C_OR  = CTRL_WIDTH'(CTRL_OR);
  localparam logic [CTRL_WIDTH-1:0] C_ADD = CTRL_WIDTH'(CTRL_ADD);
  localparam logic [CTRL_WIDTH-1:0] C_SUB = CTRL_WIDTH'(CTRL_SUB);
  localparam logic [CTRL_WIDTH-1:0] C_MUL = CTRL_WIDTH'(CTRL_MUL);
  localparam logic [CTRL_WIDTH-1:0] C_SLT = CTRL_WIDTH'(CTRL_SLT);

  // Arithmetic results are sized to DATA_WIDTH, so carries and high product bits drop.
  always_comb begin
    result = '0;
    case (ctrl)
      C_AND:   result = src_a & src_b;
      C_OR:    result = src_a | src_b;
      C_ADD:   result = src_a + src_b;
      C_SUB:   result = src_a - src_b;
      C_MUL:   result = src_a * src_b;
      C_SLT:   result = {{(DATA_WIDTH-1){1'b0}}, (src_a < src_b)};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-port round-robin front end sharing one ALU; results held per port until consumed.
//   state | meaning
//   IDLE  | waiting for an eligible requester, grant one
//   EXEC  | ALU evaluates latched operands; non-MUL result captured
//   MULW  | extra cycle for multiply, result captured
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ReqValid_0,
  output logic                  ReqReady_0,
  input  logic [DATA_WIDTH-1:0] ReqSrcA_0,
  input  logic [DATA_WIDTH-1:0] ReqSrcB_0,
  input  logic [CTRL_WIDTH-1:0] ReqCtrl_0,
  output logic                  RespValid_0,
  input  logic                  RespReady_0,
  output logic [DATA_WIDTH-1:0] RespResult_0,
  input  logic                  ReqValid_1,
  output logic                  ReqReady_1,
  input  logic [DATA_WIDTH-1:0] ReqSrcA_1,
  input  logic [DATA_WIDTH-1:0] ReqSrcB_1,
  input  logic [CTRL_WIDTH-1:0] ReqCtrl_1,
  output logic                  RespValid_1,
  input  logic                  RespReady_1,
  output logic [DATA_WIDTH-1:0] RespResult_1,
  output logic                  Busy
);

  localparam logic [CTRL_WIDTH-1:0] C_MUL = CTRL_WIDTH'(CTRL_MUL);

  state_t                  state;
  state_t                  state_nxt;
  logic                    last_grant;
  logic [DATA_WIDTH-1:0]   op_a;
  logic [DATA_WIDTH-1:0]   op_b;
  logic [CTRL_WIDTH-1:0]   op_ctrl;
  logic                    op_id;
  logic                    elig_0;
  logic                    elig_1;
  logic                    grant_any;
  logic                    grant_id;
  logic                    capture;
  logic                    handshake;
  logic [DATA_WIDTH-1:0]   alu_result;

  // A port holding an unconsumed result may not issue again.
  assign elig_0 = ReqValid_0 & ~RespValid_0;
  assign elig_1 = ReqValid_1 & ~RespValid_1;

  assign grant_any = elig_0 | elig_1;
  assign grant_id  = (elig_0 & elig_1) ? ~last_grant : elig_1;

  assign handshake = (ReqValid_0 & ReqReady_0) | (ReqValid_1 & ReqReady_1);
  assign Busy      = (state != ST_IDLE) && !RST;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    capture    = 1'b0;
    ReqReady_0 = 1'b0;
    ReqReady_1 = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grant_any && !RST) begin
          ReqReady_0 = ~grant_id;
          ReqReady_1 = grant_id;
          state_nxt  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (op_ctrl == C_MUL) begin
          state_nxt = ST_MULW;
        end else begin
          capture   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_MULW: begin
        capture   = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      last_grant   <= 1'b1;
      op_a         <= '0;
      op_b         <= '0;
      op_ctrl      <= '0;
      op_id        <= 1'b0;
      RespValid_0  <= 1'b0;
      RespValid_1  <= 1'b0;
      RespResult_0 <= '0;
      RespResult_1 <= '0;
    end else begin
      if (handshake) begin
        op_a       <= grant_id ? ReqSrcA_1 : ReqSrcA_0;
        op_b       <= grant_id ? ReqSrcB_1 : ReqSrcB_0;
        op_ctrl    <= grant_id ? ReqCtrl_1 : ReqCtrl_0;
        op_id      <= grant_id;
        last_grant <= grant_id;
      end
      if (RespValid_0 && RespReady_0) RespValid_0 <= 1'b0;
      if (RespValid_1 && RespReady_1) RespValid_1 <= 1'b0;
      // The target port was idle when granted, so capture never collides with a clear.
      if (capture) begin
        if (op_id) begin
          RespValid_1  <= 1'b1;
          RespResult_1 <= alu_result;
        end else begin
          RespValid_0  <= 1'b1;
          RespResult_0 <= alu_result;
        end
      end
    end
  end

  alu_arbiter_alu #(
    .DATA_WIDTH(DATA_WIDTH),
    .CTRL_WIDTH(CTRL_WIDTH)
  ) u_alu (
    .src_a (op_a),
    .src_b (op_b),
    .ctrl  (op_ctrl),
    .result(alu_result)
  );

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus random traffic against a cycle-count reference model.
module tb_alu_arbiter;
  localparam int DW = 32;
  localparam int CW = 3;

  logic CLK = 1'b0;
  logic RST;
  logic ReqValid_0, ReqReady_0, RespValid_0, RespReady_0;
  logic ReqValid_1, ReqReady_1, RespValid_1, RespReady_1;
  logic [DW-1:0] ReqSrcA_0, ReqSrcB_0, RespResult_0;
  logic [DW-1:0] ReqSrcA_1, ReqSrcB_1, RespResult_1;
  logic [CW-1:0] ReqCtrl_0, ReqCtrl_1;
  logic Busy;

  int total = 0;
  int bad = 0;

  always #5 CLK = ~CLK;

  alu_arbiter #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) dut (
    .CLK(CLK), .RST(RST),
    .ReqValid_0(ReqValid_0), .ReqReady_0(ReqReady_0), .ReqSrcA_0(ReqSrcA_0), .ReqSrcB_0(ReqSrcB_0),
    .ReqCtrl_0(ReqCtrl_0), .RespValid_0(RespValid_0), .RespReady_0(RespReady_0), .RespResult_0(RespResult_0),
    .ReqValid_1(ReqValid_1), .ReqReady_1(ReqReady_1), .ReqSrcA_1(ReqSrcA_1), .ReqSrcB_1(ReqSrcB_1),
    .ReqCtrl_1(ReqCtrl_1), .RespValid_1(RespValid_1), .RespReady_1(RespReady_1), .RespResult_1(RespResult_1),
    .Busy(Busy)
  );

  function automatic logic [DW-1:0] ref_alu(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [CW-1:0] c);
    longint unsigned x;
    longint unsigned y;
    x = 64'(a);
    y = 64'(b);
    case (c)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return DW'(x + y);
      3'd4: return DW'(x - y);
      3'd5: return DW'(x * y);
      3'd6: return (x < y) ? DW'(1) : DW'(0);
      default: return '0;
    endcase
  endfunction

  task automatic drive(input int p, input logic v, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [CW-1:0] c);
    if (p == 0) begin
      ReqValid_0 = v; ReqSrcA_0 = a; ReqSrcB_0 = b; ReqCtrl_0 = c;
    end else begin
      ReqValid_1 = v; ReqSrcA_1 = a; ReqSrcB_1 = b; ReqCtrl_1 = c;
    end
  endtask

  task automatic idle_inputs();
    drive(0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, '0, '0, '0);
    RespReady_0 = 1'b0;
    RespReady_1 = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    idle_inputs();
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    RST = 1'b1;
    drive(0, 1'b1, 32'd1, 32'd2, 3'd2);
    drive(1, 1'b1, 32'd3, 32'd4, 3'd2);
    RespReady_0 = 1'b0; RespReady_1 = 1'b0;
    #1;
    total++; if (ReqReady_0 !== 1'b0) begin bad++; $display("FAIL rst_ready0: got %b want 0", ReqReady_0); end
    total++; if (ReqReady_1 !== 1'b0) begin bad++; $display("FAIL rst_ready1: got %b want 0", ReqReady_1); end
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", Busy); end
    @(negedge CLK); #1;
    total++; if (RespValid_0 !== 1'b0 || RespValid_1 !== 1'b0) begin bad++; $display("FAIL rst_respvalid: got %b%b want 00", RespValid_1, RespValid_0); end
    total++; if (RespResult_0 !== '0 || RespResult_1 !== '0) begin bad++; $display("FAIL rst_result: got %h %h want 0 0", RespResult_0, RespResult_1); end
    total++; if (ReqReady_0 !== 1'b0) begin bad++; $display("FAIL rst_ready0_hold: got %b want 0", ReqReady_0); end
    idle_inputs();
    RST = 1'b0;
  endtask

  task automatic test_add();
    @(negedge CLK);
    RespReady_0 = 1'b1;
    drive(0, 1'b1, 32'd5, 32'd7, 3'b010);
    #1;
    total++; if (ReqReady_0 !== 1'b1) begin bad++; $display("FAIL add_ready: got %b want 1", ReqReady_0); end
    @(negedge CLK);
    drive(0, 1'b0, '0, '0, '0);
    #1;
    total++; if (Busy !== 1'b1) begin bad++; $display("FAIL add_busy: got %b want 1", Busy); end
    total++; if (RespValid_0 !== 1'b0) begin bad++; $display("FAIL add_early: got %b want 0", RespValid_0); end
    @(negedge CLK); #1;
    total++; if (RespValid_0 !== 1'b1) begin bad++; $display("FAIL add_valid: got %b want 1", RespValid_0); end
    total++; if (RespResult_0 !== 32'd12) begin bad++; $display("FAIL add_result: got %0d want 12", RespResult_0); end
    @(negedge CLK); #1;
    total++; if (RespValid_0 !== 1'b0) begin bad++; $display("FAIL add_clear: got %b want 0", RespValid_0); end
  endtask

  task automatic test_tie();
    do_reset();
    @(negedge CLK);
    RespReady_0 = 1'b1; RespReady_1 = 1'b1;
    drive(0, 1'b1, 32'd9, 32'd4, 3'b100);
    drive(1, 1'b1, 32'hF0, 32'h0F, 3'b001);
    #1;
    total++; if (ReqReady_0 !== 1'b1 || ReqReady_1 !== 1'b0) begin bad++; $display("FAIL tie_first: got %b%b want 01", ReqReady_1, ReqReady_0); end
    @(negedge CLK);
    drive(0, 1'b0, '0, '0, '0);
    #1;
    total++; if (ReqReady_1 !== 1'b0) begin bad++; $display("FAIL tie_exec_ready: got %b want 0", ReqReady_1); end
    @(negedge CLK); #1;
    total++; if (RespValid_0 !== 1'b1 || RespResult_0 !== 32'd5) begin bad++; $display("FAIL tie_sub: got v=%b %h want v=1 5", RespValid_0, RespResult_0); end
    total++; if (ReqReady_1 !== 1'b1) begin bad++; $display("FAIL tie_second: got %b want 1", ReqReady_1); end
    @(negedge CLK);
    drive(1, 1'b0, '0, '0, '0);
    @(negedge CLK); #1;
    total++; if (RespValid_1 !== 1'b1 || RespResult_1 !== 32'hFF) begin bad++; $display("FAIL tie_or: got v=%b %h want v=1 ff", RespValid_1, RespResult_1); end
    @(negedge CLK);
    drive(0, 1'b1, 32'd1, 32'd1, 3'b000);
    drive(1, 1'b1, 32'd2, 32'd2, 3'b000);
    #1;
    total++; if (ReqReady_0 !== 1'b1 || ReqReady_1 !== 1'b0) begin bad++; $display("FAIL tie_next: got %b%b want 01", ReqReady_1, ReqReady_0); end
    @(negedge CLK);
    drive(0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, '0, '0, '0);
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_mul();
    @(negedge CLK);
    RespReady_1 = 1'b1;
    drive(1, 1'b1, 32'h10000, 32'h10000, 3'b101);
    #1;
    total++; if (ReqReady_1 !== 1'b1) begin bad++; $display("FAIL mul_ready: got %b want 1", ReqReady_1); end
    @(negedge CLK);
    drive(1, 1'b0, '0, '0, '0);
    #1;
    total++; if (Busy !== 1'b1) begin bad++; $display("FAIL mul_busy1: got %b want 1", Busy); end
    @(negedge CLK); #1;
    total++; if (Busy !== 1'b1 || RespValid_1 !== 1'b0) begin bad++; $display("FAIL mul_busy2: got busy=%b v=%b want 1 0", Busy, RespValid_1); end
    @(negedge CLK); #1;
    total++; if (RespValid_1 !== 1'b1 || RespResult_1 !== 32'h0) begin bad++; $display("FAIL mul_result: got v=%b %h want v=1 0", RespValid_1, RespResult_1); end
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL mul_idle: got %b want 0", Busy); end
    @(negedge CLK); #1;
    total++; if (RespValid_1 !== 1'b0) begin bad++; $display("FAIL mul_clear: got %b want 0", RespValid_1); end
  endtask

  task automatic test_held();
    @(negedge CLK);
    RespReady_0 = 1'b0; RespReady_1 = 1'b1;
    drive(0, 1'b1, 32'd1, 32'd2, 3'b010);
    #1;
    total++; if (ReqReady_0 !== 1'b1) begin bad++; $display("FAIL held_ready: got %b want 1", ReqReady_0); end
    @(negedge CLK);
    drive(0, 1'b0, '0, '0, '0);
    @(negedge CLK);
    drive(0, 1'b1, 32'd6, 32'd3, 3'b000);
    drive(1, 1'b1, 32'd10, 32'd20, 3'b010);
    #1;
    total++; if (RespValid_0 !== 1'b1 || RespResult_0 !== 32'd3) begin bad++; $display("FAIL held_resp: got v=%b %h want v=1 3", RespValid_0, RespResult_0); end
    total++; if (ReqReady_0 !== 1'b0 || ReqReady_1 !== 1'b1) begin bad++; $display("FAIL held_grant1: got %b%b want 10", ReqReady_1, ReqReady_0); end
    repeat (2) @(negedge CLK);
    #1;
    total++; if (RespValid_1 !== 1'b1 || RespResult_1 !== 32'd30) begin bad++; $display("FAIL held_p1: got v=%b %h want v=1 1e", RespValid_1, RespResult_1); end
    total++; if (RespValid_0 !== 1'b1 || RespResult_0 !== 32'd3) begin bad++; $display("FAIL held_keep: got v=%b %h want v=1 3", RespValid_0, RespResult_0); end
    @(negedge CLK); #1;
    total++; if (ReqReady_0 !== 1'b0 || ReqReady_1 !== 1'b1) begin bad++; $display("FAIL held_grant2: got %b%b want 10", ReqReady_1, ReqReady_0); end
    @(negedge CLK);
    drive(1, 1'b0, '0, '0, '0);
    RespReady_0 = 1'b1;
    @(negedge CLK); #1;
    total++; if (RespValid_0 !== 1'b0 || ReqReady_0 !== 1'b1) begin bad++; $display("FAIL held_release: got v=%b rdy=%b want 0 1", RespValid_0, ReqReady_0); end
    @(negedge CLK);
    drive(0, 1'b0, '0, '0, '0);
    repeat (4) @(negedge CLK);
  endtask

  task automatic test_illegal();
    logic [CW-1:0] c;
    for (int k = 0; k < 2; k++) begin
      c = (k == 0) ? 3'b111 : 3'b110;
      @(negedge CLK);
      RespReady_0 = 1'b1;
      drive(0, 1'b1, 32'd3, 32'd8, c);
      #1;
      total++; if (ReqReady_0 !== 1'b1) begin bad++; $display("FAIL ctrl%0d_ready: got %b want 1", c, ReqReady_0); end
      @(negedge CLK);
      drive(0, 1'b0, '0, '0, '0);
      @(negedge CLK); #1;
      total++; if (RespValid_0 !== 1'b1 || RespResult_0 !== ref_alu(32'd3, 32'd8, c)) begin bad++; $display("FAIL ctrl%0d_result: got v=%b %h want v=1 %h", c, RespValid_0, RespResult_0, ref_alu(32'd3, 32'd8, c)); end
      @(negedge CLK);
    end
  endtask

  task automatic test_rst_mulw();
    @(negedge CLK);
    RespReady_0 = 1'b1;
    drive(0, 1'b1, 32'd3, 32'd4, 3'b101);
    #1;
    total++; if (ReqReady_0 !== 1'b1) begin bad++; $display("FAIL rstmul_ready: got %b want 1", ReqReady_0); end
    @(negedge CLK);
    drive(0, 1'b0, '0, '0, '0);
    @(negedge CLK); #1;
    total++; if (Busy !== 1'b1) begin bad++; $display("FAIL rstmul_mulw: got %b want 1", Busy); end
    RST = 1'b1;
    #1;
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL rstmul_busy_rst: got %b want 0", Busy); end
    @(negedge CLK);
    RST = 1'b0;
    #1;
    total++; if (Busy !== 1'b0 || RespValid_0 !== 1'b0) begin bad++; $display("FAIL rstmul_idle: got busy=%b v=%b want 0 0", Busy, RespValid_0); end
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK); #1;
      total++; if (RespValid_0 !== 1'b0 || RespValid_1 !== 1'b0) begin bad++; $display("FAIL rstmul_noresp%0d: got %b%b want 00", k, RespValid_1, RespValid_0); end
    end
  endtask

  task automatic test_random();
    logic          v [2];
    logic [DW-1:0] a [2];
    logic [DW-1:0] b [2];
    logic [CW-1:0] c [2];
    logic          rdy [2];
    logic          rv [2];
    logic [DW-1:0] rr [2];
    int            busy_cnt;
    int            ip;
    logic [DW-1:0] ires;
    logic          last;
    logic          e0, e1, any, g;
    do_reset();
    for (int p = 0; p < 2; p++) begin
      v[p] = 1'b0; a[p] = '0; b[p] = '0; c[p] = '0; rdy[p] = 1'b0; rv[p] = 1'b0; rr[p] = '0;
    end
    busy_cnt = 0; ip = 0; ires = '0; last = 1'b1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge CLK);
      for (int p = 0; p < 2; p++) begin
        if (!v[p] && $urandom_range(0, 1) == 1) begin
          v[p] = 1'b1;
          a[p] = ($urandom_range(0, 1) == 1) ? DW'($urandom) : DW'($urandom_range(0, 20));
          b[p] = ($urandom_range(0, 1) == 1) ? DW'($urandom) : DW'($urandom_range(0, 20));
          c[p] = CW'($urandom_range(0, 7));
        end
        rdy[p] = ($urandom_range(0, 3) != 0);
        drive(p, v[p], a[p], b[p], c[p]);
      end
      RespReady_0 = rdy[0];
      RespReady_1 = rdy[1];
      #1;
      e0 = (busy_cnt == 0) && v[0] && !rv[0];
      e1 = (busy_cnt == 0) && v[1] && !rv[1];
      any = e0 || e1;
      g = (e0 && e1) ? !last : e1;
      total++; if (ReqReady_0 !== (any && !g) || ReqReady_1 !== (any && g)) begin bad++; $display("FAIL rnd_ready c%0d: got %b%b want %b%b", cyc, ReqReady_1, ReqReady_0, any && g, any && !g); end
      total++; if (Busy !== (busy_cnt != 0)) begin bad++; $display("FAIL rnd_busy c%0d: got %b want %b", cyc, Busy, busy_cnt != 0); end
      total++; if (RespValid_0 !== rv[0] || RespValid_1 !== rv[1]) begin bad++; $display("FAIL rnd_valid c%0d: got %b%b want %b%b", cyc, RespValid_1, RespValid_0, rv[1], rv[0]); end
      if (rv[0]) begin
        total++; if (RespResult_0 !== rr[0]) begin bad++; $display("FAIL rnd_result0 c%0d: got %h want %h", cyc, RespResult_0, rr[0]); end
      end
      if (rv[1]) begin
        total++; if (RespResult_1 !== rr[1]) begin bad++; $display("FAIL rnd_result1 c%0d: got %h want %h", cyc, RespResult_1, rr[1]); end
      end
      for (int p = 0; p < 2; p++) if (rv[p] && rdy[p]) rv[p] = 1'b0;
      if (busy_cnt == 1) begin
        rv[ip] = 1'b1; rr[ip] = ires; busy_cnt = 0;
      end else if (busy_cnt == 2) begin
        busy_cnt = 1;
      end
      if (any) begin
        ip = g ? 1 : 0;
        busy_cnt = (c[ip] == 3'b101) ? 2 : 1;
        ires = ref_alu(a[ip], b[ip], c[ip]);
        last = g;
        v[ip] = 1'b0;
      end
    end
  endtask

  initial begin
    RST = 1'b1;
    idle_inputs();
    test_reset();
    test_add();
    test_tie();
    test_mul();
    test_held();
    test_illegal();
    test_rst_mulw();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
